// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM responder.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  localparam int unsigned DefAddrBase   = 1024;
  localparam int unsigned DefSramAw     = 18;
  localparam int unsigned DefWaitCycles = 2;

  // Legal WAIT_CYCLES range; the counter is sized for WaitMax.
  localparam int unsigned WaitMin = 1;
  localparam int unsigned WaitMax = 15;
  localparam int unsigned CntW    = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag; times each half-word phase.
module sram_wait_counter
  import sram_responder_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_responder.sv
// Serialises 32-bit MEM-stage accesses into two 16-bit async SRAM phases with
// programmable wait states. Optional last-word buffer: SRAM_LAST_WORD_BUF_EN.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DefAddrBase,
  parameter int unsigned SRAM_AW     = DefSramAw,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_CYCLES - 1);

  state_e             state_d, state_q;
  logic [SRAM_AW-2:0] word_d, word_q;
  logic [31:0]        wdata_d, wdata_q;
  logic               write_d, write_q;
  logic [31:0]        rdata_d, rdata_q;
  logic               cnt_load, cnt_zero;
  logic               buf_hit;

  // Word index relative to the base; wraps modulo the SRAM size.
  logic [31:0] addr_off;
  assign addr_off = address - ADDR_BASE;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

  sram_wait_counter u_wait_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (WaitLoad),
    .zero_o     (cnt_zero)
  );

  // Next-state, request latch and read capture.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    ready    = 1'b1;
    cnt_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_hit) begin
          rdata_d = rdata;
        end else if (wr_en | rd_en) begin
          ready    = 1'b0;
          state_d  = StLo;
          cnt_load = 1'b1;
          word_d   = addr_off[SRAM_AW:2];
          wdata_d  = wdata;
          write_d  = wr_en;
        end
      end
      StLo: begin
        ready = 1'b0;
        if (cnt_zero) begin
          if (!write_q) rdata_d[15:0] = sram_dq_in;
          state_d  = StHi;
          cnt_load = 1'b1;
        end
      end
      StHi: begin
        ready = 1'b0;
        if (cnt_zero) begin
          if (!write_q) rdata_d[31:16] = sram_dq_in;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins; we_n releases on the last cycle of a phase for address/data hold.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_q == StLo || state_q == StHi) begin
      sram_addr = {word_q, state_q == StHi};
      if (write_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = cnt_zero;
      end
    end
  end

`ifdef SRAM_LAST_WORD_BUF_EN
  logic               buf_valid_d, buf_valid_q;
  logic [SRAM_AW-2:0] buf_word_d, buf_word_q;
  logic [31:0]        buf_data_d, buf_data_q;

  assign buf_hit = (state_q == StIdle) && rd_en && !wr_en && buf_valid_q &&
                   (buf_word_q == addr_off[SRAM_AW:2]);
  assign rdata   = buf_hit ? buf_data_q : rdata_q;

  // Refresh the entry with whichever word just completed.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (state_q == StDone) begin
      buf_valid_d = 1'b1;
      buf_word_d  = word_q;
      buf_data_d  = write_q ? wdata_q : rdata_q;
    end
  end

  // Buffer registers; reset only needs to drop valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign rdata   = rdata_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder with a behavioural async SRAM.
module tb_sram_responder;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  sram_responder dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: async read, write while we_n is low.
  logic [15:0] mem [0:(1<<AW)-1];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (sram_dq_oe && !sram_we_n) mem[sram_addr] <= sram_dq_out;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails = 0;
  int   mon_stall = 0;

  // Model of the optional last-word buffer.
  bit          mbuf_v = 1'b0;
  logic [AW-2:0] mbuf_w = '0;
  logic [31:0] mbuf_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [AW-2:0] word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[AW:2];
  endfunction

  // Monitor: counts stall cycles, pops an expectation when ready returns.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mon_stall > 0 && exp_q.size() > 0) e = exp_q.pop_front();
        mon_stall = 0;
      end else if (!ready) begin
        mon_stall++;
      end else if (mon_stall > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected completion: stall %0d with no pending request", mon_stall);
        end else begin
          e = exp_q.pop_front();
          check("stall cycles", mon_stall, e.stall);
          if (e.is_read) check("read data", rdata, e.data);
        end
        mon_stall = 0;
      end
    end
  end

  // Issue one access starting just after a rising edge; returns just after the edge leaving DONE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    bit   hit;
    n   = 0;
    hit = 1'b0;
`ifdef SRAM_LAST_WORD_BUF_EN
    hit = rd && !wr && mbuf_v && (mbuf_w == word_of(a));
`endif
    wr_en   = wr;
    rd_en   = rd;
    address = a;
    wdata   = d;
    if (hit) begin
`ifdef SRAM_LAST_WORD_BUF_EN
      #1;
      check("buffer hit ready", {31'b0, ready}, 32'd1);
      check("buffer hit data", rdata, exp_rd);
      check("buffer hit no sram", {30'b0, sram_dq_oe, sram_we_n}, 32'd1);
`endif
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
    end else begin
      e.is_read = !wr;
      e.data    = exp_rd;
      e.stall   = 5;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      do begin
        @(negedge clk);
        n++;
      end while (ready !== 1'b1 && n < 40);
      if (n >= 40) check("access timeout", {31'b0, ready}, 32'd1);
      @(posedge clk);
      #1;
      mbuf_v = 1'b1;
      mbuf_w = word_of(a);
      mbuf_d = wr ? d : exp_rd;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    exp_t e;
    int   n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'b0, ready}, 32'd1);
    check("reset rdata", rdata, 32'h0);
    check("reset sram_addr", {14'b0, sram_addr}, 32'h0);
    check("reset dq_out", {16'b0, sram_dq_out}, 32'h0);
    check("reset oe", {31'b0, sram_dq_oe}, 32'h0);
    check("reset we_n", {31'b0, sram_we_n}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Traced write of 0xDEADBEEF to 0x408 -> half-words 4 and 5.
    e.is_read = 1'b0;
    e.data    = '0;
    e.stall   = 5;
    exp_q.push_back(e);
    wr_en   = 1'b1;
    address = 32'h408;
    wdata   = 32'hDEADBEEF;
    #1 check("same-cycle freeze", {31'b0, ready}, 32'h0);
    @(posedge clk);
    #1 wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("write sram_addr", {14'b0, sram_addr}, (i < 2) ? 32'h4 : 32'h5);
      check("write dq_out", {16'b0, sram_dq_out}, (i < 2) ? 32'hBEEF : 32'hDEAD);
      check("write oe", {31'b0, sram_dq_oe}, 32'd1);
      check("write we_n", {31'b0, sram_we_n}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    mbuf_v = 1'b1;
    mbuf_w = word_of(32'h408);
    mbuf_d = 32'hDEADBEEF;
    check("sram lo half", {16'b0, mem[4]}, 32'hBEEF);
    check("sram hi half", {16'b0, mem[5]}, 32'hDEAD);

    // Back-to-back reads.
    access(1'b1, 1'b0, 32'h40C, 32'h22221111, 32'h0);
    access(1'b0, 1'b1, 32'h408, 32'h0, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h40C, 32'h0, 32'h22221111);

    // Both enables high: treated as a write; rdata holds last read.
    access(1'b1, 1'b1, 32'h400, 32'h12345678, 32'h0);
    check("both-high lo", {16'b0, mem[0]}, 32'h5678);
    check("both-high hi", {16'b0, mem[1]}, 32'h1234);
    check("rdata held over write", rdata, 32'h22221111);
    access(1'b0, 1'b1, 32'h400, 32'h0, 32'h12345678);

    // Below-base address wraps to the top of the SRAM.
    access(1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 32'h0);
    check("wrap lo", {16'b0, mem[18'h3FFFE]}, 32'hF00D);
    check("wrap hi", {16'b0, mem[18'h3FFFF]}, 32'h0BAD);
    access(1'b0, 1'b1, 32'h3FC, 32'h0, 32'h0BADF00D);

    // Reset during the HI phase of a write to 0x420 (half-words 0x10/0x11).
    e.is_read = 1'b0;
    e.data    = '0;
    e.stall   = 5;
    exp_q.push_back(e);
    wr_en   = 1'b1;
    address = 32'h420;
    wdata   = 32'hA5A55A5A;
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid reset ready", {31'b0, ready}, 32'd1);
    check("mid reset we_n", {31'b0, sram_we_n}, 32'd1);
    check("mid reset oe", {31'b0, sram_dq_oe}, 32'h0);
    check("mid reset partial lo", {16'b0, mem[18'h10]}, 32'h5A5A);
    mbuf_v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    access(1'b0, 1'b1, 32'h408, 32'h0, 32'hDEADBEEF);

    // Last-word buffer scenario; plain SRAM accesses when the buffer is absent.
    access(1'b1, 1'b0, 32'h414, 32'h76543210, 32'h0);
    access(1'b1, 1'b0, 32'h410, 32'hCAFEF00D, 32'h0);
    access(1'b0, 1'b1, 32'h410, 32'h0, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h414, 32'h0, 32'h76543210);

    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
